// File: rtl/framebuffer_swap_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// framebuffer_swap_if : renderer, writer and scan-out signals for the
//                       double-buffer swap controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface framebuffer_swap_if #(
  parameter int ADDR_WIDTH          = 32,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int FRAME_CNT_WIDTH     = 16
);
  logic                           swap_req;
  logic                           swap_ready;
  logic                           vsync;
  logic                           commit_fb;
  logic [ADDR_WIDTH-1:0]          fb_addr;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size;
  logic                           fb_committed;
  logic [ADDR_WIDTH-1:0]          disp_fb_addr;
  logic                           front_idx;
  logic                           flip_done;
  logic [FRAME_CNT_WIDTH-1:0]     frame_count;

  // Controller side
  modport master (
    input  swap_req, vsync, fb_committed,
    output swap_ready, commit_fb, fb_addr, fb_size,
           disp_fb_addr, front_idx, flip_done, frame_count
  );

  // Renderer / writer / display side
  modport slave (
    output swap_req, vsync, fb_committed,
    input  swap_ready, commit_fb, fb_addr, fb_size,
           disp_fb_addr, front_idx, flip_done, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/framebuffer_swap_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// framebuffer_swap_controller : commits the back buffer to the writer, waits
//                               for completion (and optionally vsync), flips.
// Revision: 1.0
// ---------------------------------------------------------------------------
module framebuffer_swap_controller #(
  parameter int ADDR_WIDTH          = 32,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int FRAME_CNT_WIDTH     = 16
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic [ADDR_WIDTH-1:0]          cfg_fb0_addr_i,
  input  logic [ADDR_WIDTH-1:0]          cfg_fb1_addr_i,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] cfg_fb_size_i,
  input  logic                           cfg_wait_vsync_i,
  framebuffer_swap_if.master             bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COMMIT     = 3'd1,
    ST_WRITE      = 3'd2,
    ST_WAIT_VSYNC = 3'd3,
    ST_FLIP       = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic                           commit_fb_q, commit_fb_d;
  logic [ADDR_WIDTH-1:0]          fb_addr_q, fb_addr_d;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size_q, fb_size_d;
  logic                           front_idx_q, front_idx_d;
  logic                           flip_done_q, flip_done_d;
  logic [FRAME_CNT_WIDTH-1:0]     frame_count_q, frame_count_d;
  logic                           swap_ready_w;

  assign swap_ready_w = (state_q == ST_IDLE) && bus.fb_committed;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      commit_fb_q   <= 1'b0;
      fb_addr_q     <= '0;
      fb_size_q     <= '0;
      front_idx_q   <= 1'b0;
      flip_done_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      commit_fb_q   <= commit_fb_d;
      fb_addr_q     <= fb_addr_d;
      fb_size_q     <= fb_size_d;
      front_idx_q   <= front_idx_d;
      flip_done_q   <= flip_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    commit_fb_d   = commit_fb_q;
    fb_addr_d     = fb_addr_q;
    fb_size_d     = fb_size_q;
    front_idx_d   = front_idx_q;
    flip_done_d   = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.swap_req && swap_ready_w) begin
          state_d     = ST_COMMIT;
          commit_fb_d = 1'b1;
          // The back buffer is whichever one is not being scanned out
          fb_addr_d   = front_idx_q ? cfg_fb0_addr_i : cfg_fb1_addr_i;
          fb_size_d   = cfg_fb_size_i;
        end
      end
      ST_COMMIT: begin
        // Dropping commit only after the writer goes busy avoids a re-trigger
        if (!bus.fb_committed) begin
          commit_fb_d = 1'b0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.fb_committed) begin
          state_d = cfg_wait_vsync_i ? ST_WAIT_VSYNC : ST_FLIP;
        end
      end
      ST_WAIT_VSYNC: begin
        if (bus.vsync) begin
          state_d = ST_FLIP;
        end
      end
      ST_FLIP: begin
        front_idx_d   = ~front_idx_q;
        flip_done_d   = 1'b1;
        frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.swap_ready   = swap_ready_w;
  assign bus.commit_fb    = commit_fb_q;
  assign bus.fb_addr      = fb_addr_q;
  assign bus.fb_size      = fb_size_q;
  assign bus.disp_fb_addr = front_idx_q ? cfg_fb1_addr_i : cfg_fb0_addr_i;
  assign bus.front_idx    = front_idx_q;
  assign bus.flip_done    = flip_done_q;
  assign bus.frame_count  = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_swap_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_framebuffer_swap_controller : self-checking bench with writer/vsync model
//                                  and a frame-level reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_framebuffer_swap_controller;

  localparam int          AW  = 32;
  localparam int          SW  = 20;
  localparam int          CW  = 8;  // narrow counter keeps the wrap test short
  localparam logic [AW-1:0] FB0 = 32'h1000_0000;
  localparam logic [AW-1:0] FB1 = 32'h1010_0000;

  logic          aclk;
  logic          resetn;
  logic [AW-1:0] cfg_fb0_addr;
  logic [AW-1:0] cfg_fb1_addr;
  logic [SW-1:0] cfg_fb_size;
  logic          cfg_wait_vsync;

  int n_checks;
  int n_fail;

  // Reference model: which buffer is on screen and how many flips happened
  logic          m_front;
  logic [CW-1:0] m_count;

  framebuffer_swap_if #(
    .ADDR_WIDTH(AW), .FB_SIZE_IN_PIXEL_LG(SW), .FRAME_CNT_WIDTH(CW)
  ) bus ();

  framebuffer_swap_controller #(
    .ADDR_WIDTH(AW), .FB_SIZE_IN_PIXEL_LG(SW), .FRAME_CNT_WIDTH(CW)
  ) dut (
    .aclk             (aclk),
    .resetn           (resetn),
    .cfg_fb0_addr_i   (cfg_fb0_addr),
    .cfg_fb1_addr_i   (cfg_fb1_addr),
    .cfg_fb_size_i    (cfg_fb_size),
    .cfg_wait_vsync_i (cfg_wait_vsync),
    .bus              (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time budget expired");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flip_state(input string tag);
    check_val({tag, "_front"}, bus.front_idx, m_front);
    check_val({tag, "_count"}, bus.frame_count, m_count);
    check_val({tag, "_disp"}, bus.disp_fb_addr, m_front ? FB1 : FB0);
  endtask

  // One full frame, starting and ending at a negedge. The writer drops
  // fb_committed one cycle after commit_fb and raises it wlen cycles later.
  task automatic do_frame(input logic [SW-1:0] sz, input int wlen, input bit wv,
                          input int vdelay, input bit hold, input bit vs_in_write);
    logic [AW-1:0] exp_addr;
    exp_addr       = m_front ? FB0 : FB1;
    cfg_fb_size    = sz;
    cfg_wait_vsync = wv;
    bus.swap_req   = 1'b1;
    check_val("ready_idle", bus.swap_ready, 1'b1);
    @(negedge aclk);
    check_val("commit_set", bus.commit_fb, 1'b1);
    check_val("fb_addr", bus.fb_addr, exp_addr);
    check_val("fb_size", bus.fb_size, sz);
    check_val("ready_busy", bus.swap_ready, 1'b0);
    if (!hold) bus.swap_req = 1'b0;
    cfg_fb_size      = ~sz;
    bus.fb_committed = 1'b0;
    @(negedge aclk);
    check_val("commit_drop", bus.commit_fb, 1'b0);
    for (int i = 1; i < wlen; i++) begin
      bus.vsync = vs_in_write && (i == 1);
      @(negedge aclk);
      bus.vsync = 1'b0;
      check_val("no_early_flip", bus.flip_done, 1'b0);
      check_val("ready_write", bus.swap_ready, 1'b0);
    end
    bus.fb_committed = 1'b1;
    bus.vsync        = wv;
    @(negedge aclk);
    bus.vsync      = 1'b0;
    cfg_wait_vsync = ~wv;
    check_val("no_flip_at_done", bus.flip_done, 1'b0);
    check_val("ready_post_write", bus.swap_ready, 1'b0);
    if (wv) begin
      for (int i = 0; i < vdelay; i++) begin
        @(negedge aclk);
        check_val("wait_vsync_hold", bus.flip_done, 1'b0);
        check_val("wait_vsync_front", bus.front_idx, m_front);
      end
      bus.vsync = 1'b1;
      @(negedge aclk);
      bus.vsync = 1'b0;
      check_val("vsync_flip_delay", bus.flip_done, 1'b0);
    end
    @(negedge aclk);
    m_front = ~m_front;
    m_count = m_count + 1'b1;
    check_val("flip_pulse", bus.flip_done, 1'b1);
    check_flip_state("flip");
    check_val("fb_addr_stable", bus.fb_addr, exp_addr);
    check_val("fb_size_stable", bus.fb_size, sz);
    if (!hold) begin
      @(negedge aclk);
      check_val("flip_single", bus.flip_done, 1'b0);
      check_val("ready_after", bus.swap_ready, 1'b1);
    end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    m_front          = 1'b0;
    m_count          = '0;
    resetn           = 1'b0;
    cfg_fb0_addr     = FB0;
    cfg_fb1_addr     = FB1;
    cfg_fb_size      = '0;
    cfg_wait_vsync   = 1'b0;
    bus.swap_req     = 1'b0;
    bus.vsync        = 1'b0;
    bus.fb_committed = 1'b1;

    repeat (3) @(negedge aclk);
    check_val("rst_ready", bus.swap_ready, 1'b1);
    check_val("rst_disp", bus.disp_fb_addr, FB0);
    check_val("rst_commit", bus.commit_fb, 1'b0);
    check_val("rst_flip", bus.flip_done, 1'b0);
    check_flip_state("rst");
    bus.fb_committed = 1'b0;
    #1;
    check_val("ready_follows_wr", bus.swap_ready, 1'b0);
    bus.fb_committed = 1'b1;
    @(negedge aclk);
    resetn = 1'b1;
    @(negedge aclk);

    // Basic frame, long write, no vsync
    do_frame(SW'(76800), 200, 1'b0, 0, 1'b0, 1'b0);
    // Vsync during write and coincident with completion must be ignored
    do_frame(SW'(76800), 10, 1'b1, 3, 1'b0, 1'b1);
    // Request held across three consecutive frames
    do_frame(SW'(1000), 4, 1'b0, 0, 1'b1, 1'b0);
    do_frame(SW'(2000), 5, 1'b1, 0, 1'b1, 1'b0);
    do_frame(SW'(3000), 3, 1'b0, 0, 1'b0, 1'b0);
    // Zero-size frame still runs the full writer handshake
    do_frame(SW'(0), 2, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      do_frame(SW'($urandom), $urandom_range(1, 20), 1'($urandom_range(0, 1)),
               $urandom_range(0, 5), 1'($urandom_range(0, 1)) && (k != 11),
               1'($urandom_range(0, 1)));
    end

    // Fast flips up to the counter's all-ones value, then one more to wrap
    while (m_count != {CW{1'b1}}) begin
      do_frame(SW'($urandom), 1, 1'b0, 0, 1'b1, 1'b0);
    end
    do_frame(SW'(5), 1, 1'b0, 0, 1'b0, 1'b0);
    check_val("count_wrap", bus.frame_count, '0);

    // Asynchronous reset in the middle of a write
    bus.swap_req = 1'b1;
    @(negedge aclk);
    bus.swap_req     = 1'b0;
    bus.fb_committed = 1'b0;
    repeat (3) @(negedge aclk);
    #2;
    resetn = 1'b0;
    #1;
    m_front = 1'b0;
    m_count = '0;
    check_val("arst_commit", bus.commit_fb, 1'b0);
    check_val("arst_fb_addr", bus.fb_addr, '0);
    check_val("arst_fb_size", bus.fb_size, '0);
    check_val("arst_flip", bus.flip_done, 1'b0);
    check_flip_state("arst");
    bus.fb_committed = 1'b1;
    #1;
    check_val("arst_ready", bus.swap_ready, 1'b1);
    @(negedge aclk);
    resetn = 1'b1;
    @(negedge aclk);
    do_frame(SW'(640), 6, 1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
